multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op  in  6  opcode, instr[31:26], from the datapath
- funct  in  6  function field, instr[5:0], from the datapath
- zero  in  1  ALU zero flag from the datapath
- control_bus  out  15  packed datapath controls
- state_out  out  4  current FSM state encoding
- illegal_op  out  1  sticky flag set by an undecoded opcode

REQ-002 SHALL pack control_bus as follows (unlisted bits 0):
- [14] IorD
- [13] MemWrite
- [12] IRWrite
- [11] PCEn
- [10] ALUSrcA
- [9] RegWrite
- [8] RegDst
- [7] MemtoReg
- [6:5] PCSrc
- [4:3] ALUSrcB
- [2:0] ALUControl

Function
REQ-003 SHALL implement a Moore main FSM with a 4-bit state register. Encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11

REQ-004 Transitions:
- FETCH->DECODE
- DECODE->MEMADR on lw(100011) or sw(101011)
- DECODE->EXECUTE on R-type(000000)
- DECODE->BRANCH on beq(000100)
- DECODE->ADDIEXEC on addi(001000)
- DECODE->JUMP on j(000010)
- MEMADR->MEMRD on lw, ->MEMWR on sw
- MEMRD->MEMWB
- ADDIEXEC->ADDIWB
- EXECUTE->ALUWB
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH

REQ-005 DECODE with any other opcode SHALL go to FETCH and set illegal_op on the next edge.

REQ-006 States 12-15 SHALL go to FETCH on the next edge.

REQ-007 Per-state asserted controls (all others 0, ALUOp=00 by default):
- FETCH: IRWrite, PCWrite, ALUSrcB=01
- DECODE: ALUSrcB=11
- MEMADR: ALUSrcA, ALUSrcB=10
- MEMRD: IorD
- MEMWB: MemtoReg, RegWrite
- MEMWR: IorD, MemWrite
- EXECUTE: ALUSrcA, ALUOp=10
- ALUWB: RegDst, RegWrite
- BRANCH: ALUSrcA, ALUOp=01, PCSrc=01, Branch
- ADDIEXEC: ALUSrcA, ALUSrcB=10
- ADDIWB: RegWrite
- JUMP: PCSrc=10, PCWrite

REQ-008 PCEn SHALL be the combinational term PCWrite | (Branch & zero), with zero-cycle latency from zero.

REQ-009 ALU decoder, combinational:
- ALUOp 00 -> 010
- ALUOp 01 -> 110
- ALUOp 11 -> 010
- ALUOp 10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->010

REQ-010 All outputs except PCEn SHALL be functions of registered state only.

REQ-011 state_out SHALL equal the state register.

REQ-012 illegal_op, once set, SHALL hold until reset.

REQ-013 Instruction latency in cycles, counting FETCH:
- lw 5
- sw, R-type, addi 4
- beq, j 3

Reset
REQ-014 reset high at a rising edge SHALL force state=FETCH and illegal_op=0 from any state, including mid-instruction; no other state SHALL be entered that cycle.

REQ-015 While in reset, and in the first cycle after it, control_bus SHALL be 0x180A (FETCH controls).

Configuration
REQ-016 Macro MC_BNE_EN, when defined:
- decodes bne (000101) in DECODE -> BRANCH
- the BRANCH state then drives PCEn = Branch & ~zero for bne and Branch & zero for beq, selected on the op value held during BRANCH

REQ-017 Without MC_BNE_EN, opcode 000101 SHALL be treated as illegal per REQ-005.

Verification
REQ-018 Reset, then op=100011 held -> state_out 0,1,2,3,4,0 over successive cycles; control_bus in FETCH = 0x180A; illegal_op=0.

REQ-019 op=000100 in BRANCH -> zero=1 gives control_bus 0xC26, and zero=0 gives 0x426 in the same cycle; next state is FETCH.

REQ-020 op=000000 in EXECUTE:
- funct=100100 -> control_bus 0x400
- funct=100101 -> 0x401
- funct=101010 -> 0x407
- funct=111111 -> 0x402

REQ-021 op=000010 -> JUMP cycle control_bus 0x842; op=111111 in DECODE -> next state FETCH, illegal_op=1 until reset.

REQ-022 Assert reset while in MEMRD -> next state_out=0, control_bus 0x180A, illegal_op=0.

REQ-023 With MC_BNE_EN, op=000101 in BRANCH and zero=0 -> control_bus 0xC26; without the macro -> illegal_op=1.

Source files
------------

// File: rtl/multicycle_control.sv
// Purpose: multicycle MIPS main control FSM + ALU decoder; optional bne decode under MC_BNE_EN.
// Latency: Moore outputs from the state register; PCEn follows zero combinationally (0 cycles).
// Backpressure: none, one state per clock; lw 5, sw/R/addi 4, beq/j 3 cycles.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic [14:0] control_bus,
    output logic [3:0]  state_out,
    output logic        illegal_op
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_en;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] pc_src;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    state_t     state;
    state_t     state_nxt;
    logic       decode_illegal;
    ctrl_t      fsm_ctrl;
    ctrl_t      ctrl;
    logic       pc_write;
    logic       branch;
    logic [1:0] alu_op;
    logic [2:0] alu_control;
    logic       br_taken;
    logic       pc_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            illegal_op <= 1'b0;
        end else begin
            state <= state_nxt;
            if (decode_illegal) begin
                illegal_op <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = FETCH;
        decode_illegal = 1'b0;
        fsm_ctrl       = '0;
        pc_write       = 1'b0;
        branch         = 1'b0;
        alu_op         = 2'b00;
        case (state)
            FETCH: begin
                state_nxt          = DECODE;
                fsm_ctrl.ir_write  = 1'b1;
                fsm_ctrl.alu_src_b = 2'b01;
                pc_write           = 1'b1;
            end
            DECODE: begin
                fsm_ctrl.alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_RTYPE:     state_nxt = EXECUTE;
                    OP_BEQ:       state_nxt = BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:       state_nxt = BRANCH;
`endif
                    OP_ADDI:      state_nxt = ADDIEXEC;
                    OP_J:         state_nxt = JUMP;
                    default:      decode_illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                state_nxt          = (op == OP_SW) ? MEMWR : MEMRD;
                fsm_ctrl.alu_src_a = 1'b1;
                fsm_ctrl.alu_src_b = 2'b10;
            end
            MEMRD: begin
                state_nxt     = MEMWB;
                fsm_ctrl.iord = 1'b1;
            end
            MEMWB: begin
                fsm_ctrl.mem_to_reg = 1'b1;
                fsm_ctrl.reg_write  = 1'b1;
            end
            MEMWR: begin
                fsm_ctrl.iord      = 1'b1;
                fsm_ctrl.mem_write = 1'b1;
            end
            EXECUTE: begin
                state_nxt          = ALUWB;
                fsm_ctrl.alu_src_a = 1'b1;
                alu_op             = 2'b10;
            end
            ALUWB: begin
                fsm_ctrl.reg_dst   = 1'b1;
                fsm_ctrl.reg_write = 1'b1;
            end
            BRANCH: begin
                fsm_ctrl.alu_src_a = 1'b1;
                fsm_ctrl.pc_src    = 2'b01;
                alu_op             = 2'b01;
                branch             = 1'b1;
            end
            ADDIEXEC: begin
                state_nxt          = ADDIWB;
                fsm_ctrl.alu_src_a = 1'b1;
                fsm_ctrl.alu_src_b = 2'b10;
            end
            ADDIWB: begin
                fsm_ctrl.reg_write = 1'b1;
            end
            JUMP: begin
                fsm_ctrl.pc_src = 2'b10;
                pc_write        = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        alu_control = 3'b010;
        case (alu_op)
            2'b01: alu_control = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
            end
            default: alu_control = 3'b010;
        endcase
    end

    // op is held through BRANCH, so it selects the branch sense directly.
`ifdef MC_BNE_EN
    assign br_taken = branch & ((op == OP_BNE) ? ~zero : zero);
`else
    assign br_taken = branch & zero;
`endif
    assign pc_en = pc_write | br_taken;

    always_comb begin
        ctrl             = fsm_ctrl;
        ctrl.pc_en       = pc_en;
        ctrl.alu_control = alu_control;
    end

    assign control_bus = ctrl;
    assign state_out   = state;

endmodule
